// File: rtl/rob_param_if.sv
// rob_param_if: bundles every non-clock/reset signal of rob_param.
//   master : dispatch, operand-lookup and CDB driver side; observes tags,
//            operand values, retirement, flush and occupancy.
//   slave  : the reorder buffer itself.
// Ports (slave view):
//   inst1/2_valid_in, inst1/2_dest_in           dispatch requests
//   inst1/2_tag_out, dispatch_stall_out         allocation result
//   rd_tag_in[4] -> rd_value_out[4], rd_ready_out[4]   operand lookup
//   cdb1/2_tag_in, _value_in, _NPC_in, _mispredicted_in completion buses
//   ret1/2_valid/dest/value/NPC/tag/mispredicted_out    retirement
//   flush_out, free_count_out, rob_full, rob_empty
interface rob_param_if #(
  parameter int ROB_DEPTH = 32,
  parameter int DATA_W    = 64
);
  localparam int PTR_W = $clog2(ROB_DEPTH);

  logic              inst1_valid_in;
  logic              inst2_valid_in;
  logic [4:0]        inst1_dest_in;
  logic [4:0]        inst2_dest_in;
  logic [7:0]        inst1_tag_out;
  logic [7:0]        inst2_tag_out;
  logic              dispatch_stall_out;

  logic [7:0]        rd_tag_in    [4];
  logic [DATA_W-1:0] rd_value_out [4];
  logic              rd_ready_out [4];

  logic [7:0]        cdb1_tag_in;
  logic [DATA_W-1:0] cdb1_value_in;
  logic [DATA_W-1:0] cdb1_NPC_in;
  logic              cdb1_mispredicted_in;
  logic [7:0]        cdb2_tag_in;
  logic [DATA_W-1:0] cdb2_value_in;
  logic [DATA_W-1:0] cdb2_NPC_in;
  logic              cdb2_mispredicted_in;

  logic              ret1_valid_out;
  logic [4:0]        ret1_dest_out;
  logic [DATA_W-1:0] ret1_value_out;
  logic [DATA_W-1:0] ret1_NPC_out;
  logic [7:0]        ret1_tag_out;
  logic              ret1_mispredicted_out;
  logic              ret2_valid_out;
  logic [4:0]        ret2_dest_out;
  logic [DATA_W-1:0] ret2_value_out;
  logic [DATA_W-1:0] ret2_NPC_out;
  logic [7:0]        ret2_tag_out;
  logic              ret2_mispredicted_out;

  logic              flush_out;
  logic [PTR_W:0]    free_count_out;
  logic              rob_full;
  logic              rob_empty;

  modport master (
    output inst1_valid_in, inst2_valid_in, inst1_dest_in, inst2_dest_in,
    input  inst1_tag_out, inst2_tag_out, dispatch_stall_out,
    output rd_tag_in,
    input  rd_value_out, rd_ready_out,
    output cdb1_tag_in, cdb1_value_in, cdb1_NPC_in, cdb1_mispredicted_in,
    output cdb2_tag_in, cdb2_value_in, cdb2_NPC_in, cdb2_mispredicted_in,
    input  ret1_valid_out, ret1_dest_out, ret1_value_out, ret1_NPC_out,
    input  ret1_tag_out, ret1_mispredicted_out,
    input  ret2_valid_out, ret2_dest_out, ret2_value_out, ret2_NPC_out,
    input  ret2_tag_out, ret2_mispredicted_out,
    input  flush_out, free_count_out, rob_full, rob_empty
  );

  modport slave (
    input  inst1_valid_in, inst2_valid_in, inst1_dest_in, inst2_dest_in,
    output inst1_tag_out, inst2_tag_out, dispatch_stall_out,
    input  rd_tag_in,
    output rd_value_out, rd_ready_out,
    input  cdb1_tag_in, cdb1_value_in, cdb1_NPC_in, cdb1_mispredicted_in,
    input  cdb2_tag_in, cdb2_value_in, cdb2_NPC_in, cdb2_mispredicted_in,
    output ret1_valid_out, ret1_dest_out, ret1_value_out, ret1_NPC_out,
    output ret1_tag_out, ret1_mispredicted_out,
    output ret2_valid_out, ret2_dest_out, ret2_value_out, ret2_NPC_out,
    output ret2_tag_out, ret2_mispredicted_out,
    output flush_out, free_count_out, rob_full, rob_empty
  );
endinterface

// File: rtl/rob_param.sv
// rob_param: parametrised two-wide reorder buffer.
//   Two dispatch slots (all-or-nothing allocation against an occupancy
//   counter), two CDB completion ports, four operand-lookup ports, two
//   in-order retire ports and a precise flush when a mispredicted branch
//   retires.
// Ports:
//   clock  : clock
//   reset  : synchronous, active-high
//   rob    : rob_param_if.slave carrying dispatch, lookup, CDB, retire,
//            flush and occupancy signals
// Parameters: ROB_DEPTH (power of two, 4..128), DATA_W, PTR_W.
// Build option: define ROB_CDB_BYPASS_EN to forward same-cycle CDB results
// to the operand-lookup ports.
module rob_param #(
  parameter int ROB_DEPTH = 32,
  parameter int DATA_W    = 64,
  parameter int PTR_W     = $clog2(ROB_DEPTH)
) (
  input logic       clock,
  input logic       reset,
  rob_param_if.slave rob
);

  localparam int         CW       = PTR_W + 1;
  localparam logic [7:0] NULL_TAG = 8'hFF;

  typedef enum logic [1:0] {
    ENTRY_EMPTY    = 2'd0,
    ENTRY_INUSE    = 2'd1,
    ENTRY_COMPLETE = 2'd2
  } entry_state_e;

  entry_state_e      state_q   [ROB_DEPTH];
  entry_state_e      state_d   [ROB_DEPTH];
  logic [4:0]        dest_q    [ROB_DEPTH];
  logic [4:0]        dest_d    [ROB_DEPTH];
  logic [DATA_W-1:0] value_q   [ROB_DEPTH];
  logic [DATA_W-1:0] value_d   [ROB_DEPTH];
  logic [DATA_W-1:0] npc_q     [ROB_DEPTH];
  logic [DATA_W-1:0] npc_d     [ROB_DEPTH];
  logic              mispred_q [ROB_DEPTH];
  logic              mispred_d [ROB_DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [PTR_W-1:0]  head_p1;
  logic [PTR_W-1:0]  tail_p1;
  logic [PTR_W-1:0]  slot2;
  logic              ret1, ret2, flush;
  logic [1:0]        n_req, n_disp, n_ret;
  logic [CW-1:0]     free_cnt;
  logic              fits, accept;
  logic [PTR_W-1:0]  rd_idx [4];

  function automatic logic [7:0] to_tag(input logic [PTR_W-1:0] idx);
    return 8'(idx);
  endfunction

  // Retirement and flush decision
  always_comb begin
    head_p1 = head_q + PTR_W'(1);
    ret1    = (state_q[head_q] == ENTRY_COMPLETE);
    // A mispredicted head stops the second retire slot so the flush is precise.
    ret2    = ret1 && (state_q[head_p1] == ENTRY_COMPLETE) && !mispred_q[head_q];
    flush   = (ret1 && mispred_q[head_q]) || (ret2 && mispred_q[head_p1]);
    n_ret   = {1'b0, ret1} + {1'b0, ret2};
  end

  // Dispatch admission: registered occupancy only, no credit for retirement
  always_comb begin
    free_cnt = CW'(ROB_DEPTH) - count_q;
    n_req    = {1'b0, rob.inst1_valid_in} + {1'b0, rob.inst2_valid_in};
    fits     = (CW'(n_req) <= free_cnt);
    accept   = (n_req != 2'd0) && !flush && fits;
    n_disp   = accept ? n_req : 2'd0;
    tail_p1  = tail_q + PTR_W'(1);
    // A lone inst2 takes the tail slot itself.
    slot2    = rob.inst1_valid_in ? tail_p1 : tail_q;

    rob.dispatch_stall_out = (n_req != 2'd0) && !flush && !fits;
    rob.inst1_tag_out      = (accept && rob.inst1_valid_in) ? to_tag(tail_q) : NULL_TAG;
    rob.inst2_tag_out      = (accept && rob.inst2_valid_in) ? to_tag(slot2)  : NULL_TAG;
  end

  // Next-state: retire, CDB completion, dispatch, then flush override
  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    value_d   = value_q;
    npc_d     = npc_q;
    mispred_d = mispred_q;
    head_d    = head_q + PTR_W'(n_ret);
    tail_d    = tail_q + PTR_W'(n_disp);
    count_d   = count_q + CW'(n_disp) - CW'(n_ret);

    if (ret1) state_d[head_q]  = ENTRY_EMPTY;
    if (ret2) state_d[head_p1] = ENTRY_EMPTY;

    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      if (state_q[i] == ENTRY_INUSE) begin
        if (rob.cdb1_tag_in == 8'(i)) begin
          state_d[i]   = ENTRY_COMPLETE;
          value_d[i]   = rob.cdb1_value_in;
          npc_d[i]     = rob.cdb1_NPC_in;
          mispred_d[i] = rob.cdb1_mispredicted_in;
        end else if (rob.cdb2_tag_in == 8'(i)) begin
          state_d[i]   = ENTRY_COMPLETE;
          value_d[i]   = rob.cdb2_value_in;
          npc_d[i]     = rob.cdb2_NPC_in;
          mispred_d[i] = rob.cdb2_mispredicted_in;
        end
      end
    end

    // Allocated slots are EMPTY in the registered state, so no CDB overlap.
    if (accept && rob.inst1_valid_in) begin
      state_d[tail_q]   = ENTRY_INUSE;
      dest_d[tail_q]    = rob.inst1_dest_in;
      value_d[tail_q]   = '0;
      npc_d[tail_q]     = '0;
      mispred_d[tail_q] = 1'b0;
    end
    if (accept && rob.inst2_valid_in) begin
      state_d[slot2]   = ENTRY_INUSE;
      dest_d[slot2]    = rob.inst2_dest_in;
      value_d[slot2]   = '0;
      npc_d[slot2]     = '0;
      mispred_d[slot2] = 1'b0;
    end

    // Flush discards this cycle's CDB writes: payload fields keep old contents.
    if (flush) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        state_d[i] = ENTRY_EMPTY;
      end
      value_d   = value_q;
      npc_d     = npc_q;
      mispred_d = mispred_q;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        state_q[i]   <= ENTRY_EMPTY;
        dest_q[i]    <= '0;
        value_q[i]   <= '0;
        npc_q[i]     <= '0;
        mispred_q[i] <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      value_q   <= value_d;
      npc_q     <= npc_d;
      mispred_q <= mispred_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Retire ports and occupancy
  always_comb begin
    rob.ret1_valid_out        = ret1;
    rob.ret1_dest_out         = ret1 ? dest_q[head_q]    : '0;
    rob.ret1_value_out        = ret1 ? value_q[head_q]   : '0;
    rob.ret1_NPC_out          = ret1 ? npc_q[head_q]     : '0;
    rob.ret1_tag_out          = ret1 ? to_tag(head_q)    : NULL_TAG;
    rob.ret1_mispredicted_out = ret1 ? mispred_q[head_q] : 1'b0;

    rob.ret2_valid_out        = ret2;
    rob.ret2_dest_out         = ret2 ? dest_q[head_p1]    : '0;
    rob.ret2_value_out        = ret2 ? value_q[head_p1]   : '0;
    rob.ret2_NPC_out          = ret2 ? npc_q[head_p1]     : '0;
    rob.ret2_tag_out          = ret2 ? to_tag(head_p1)    : NULL_TAG;
    rob.ret2_mispredicted_out = ret2 ? mispred_q[head_p1] : 1'b0;

    rob.flush_out      = flush;
    rob.free_count_out = free_cnt;
    rob.rob_full       = (count_q > CW'(ROB_DEPTH - 2));
    rob.rob_empty      = (count_q == '0);
  end

  // Operand lookup
  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      rd_idx[r]           = rob.rd_tag_in[r][PTR_W-1:0];
      rob.rd_ready_out[r] = 1'b0;
      rob.rd_value_out[r] = '0;
      if (rob.rd_tag_in[r] != NULL_TAG) begin
        rob.rd_ready_out[r] = (state_q[rd_idx[r]] == ENTRY_COMPLETE);
        rob.rd_value_out[r] = value_q[rd_idx[r]];
`ifdef ROB_CDB_BYPASS_EN
        if (!flush && (state_q[rd_idx[r]] == ENTRY_INUSE)) begin
          if (rob.cdb1_tag_in == to_tag(rd_idx[r])) begin
            rob.rd_ready_out[r] = 1'b1;
            rob.rd_value_out[r] = rob.cdb1_value_in;
          end else if (rob.cdb2_tag_in == to_tag(rd_idx[r])) begin
            rob.rd_ready_out[r] = 1'b1;
            rob.rd_value_out[r] = rob.cdb2_value_in;
          end
        end
`else
        ;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Directed testbench for rob_param (ROB_DEPTH = 8). Expected retirements are
// pushed to a scoreboard queue at dispatch, completed with the values the
// bench broadcasts, and popped against the retire ports.
module tb_rob_param;
  localparam int         D  = 8;
  localparam int         DW = 64;
  localparam logic [7:0] NT = 8'hFF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rob_param_if #(.ROB_DEPTH(D), .DATA_W(DW)) bus ();
  rob_param #(.ROB_DEPTH(D), .DATA_W(DW)) dut (.clock(clock), .reset(reset), .rob(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] tag;
    logic [4:0] dest;
  } sb_t;
  sb_t sbq[$];

  logic [DW-1:0] exp_val [D];
  logic [DW-1:0] exp_npc [D];
  logic          exp_mp  [D];
  int m_tail  = 0;
  int m_count = 0;
  int m_disp  = 0;
  int m_ret   = 0;
  bit m_flush = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic idle();
    bus.inst1_valid_in = 1'b0; bus.inst2_valid_in = 1'b0;
    bus.inst1_dest_in  = '0;   bus.inst2_dest_in  = '0;
    for (int r = 0; r < 4; r++) bus.rd_tag_in[r] = NT;
    bus.cdb1_tag_in = NT; bus.cdb1_value_in = '0; bus.cdb1_NPC_in = '0; bus.cdb1_mispredicted_in = 1'b0;
    bus.cdb2_tag_in = NT; bus.cdb2_value_in = '0; bus.cdb2_NPC_in = '0; bus.cdb2_mispredicted_in = 1'b0;
  endtask

  task automatic set_dispatch(input bit v1, input logic [4:0] d1, input bit v2, input logic [4:0] d2);
    bus.inst1_valid_in = v1; bus.inst1_dest_in = d1;
    bus.inst2_valid_in = v2; bus.inst2_dest_in = d2;
  endtask

  // cdb2 recorded first so a shared tag leaves cdb1's payload in the model.
  task automatic set_cdb(input logic [7:0] t1, input logic [DW-1:0] v1, input logic [DW-1:0] n1, input bit m1,
                         input logic [7:0] t2, input logic [DW-1:0] v2, input logic [DW-1:0] n2, input bit m2);
    bus.cdb1_tag_in = t1; bus.cdb1_value_in = v1; bus.cdb1_NPC_in = n1; bus.cdb1_mispredicted_in = m1;
    bus.cdb2_tag_in = t2; bus.cdb2_value_in = v2; bus.cdb2_NPC_in = n2; bus.cdb2_mispredicted_in = m2;
    if (t2 != NT) begin exp_val[int'(t2)] = v2; exp_npc[int'(t2)] = n2; exp_mp[int'(t2)] = m2; end
    if (t1 != NT) begin exp_val[int'(t1)] = v1; exp_npc[int'(t1)] = n1; exp_mp[int'(t1)] = m1; end
  endtask

  task automatic push_entry(input logic [7:0] t, input logic [4:0] d);
    sb_t e;
    e.tag = t; e.dest = d;
    sbq.push_back(e);
    exp_val[int'(t)] = '0; exp_npc[int'(t)] = '0; exp_mp[int'(t)] = 1'b0;
  endtask

  // Sample at the falling edge: scoreboard retire, occupancy and dispatch checks.
  task automatic sample();
    sb_t e;
    int n, idx;
    bit acc;
    logic [7:0] t1, t2;
    @(negedge clock);
    m_ret = 0; m_flush = 1'b0;
    if (bus.ret1_valid_out === 1'b1) begin
      if (sbq.size() == 0) chk("ret1_spurious", bus.ret1_valid_out, 0);
      else begin
        e = sbq.pop_front(); idx = int'(e.tag);
        chk("ret1_tag", bus.ret1_tag_out, e.tag);
        chk("ret1_dest", bus.ret1_dest_out, e.dest);
        chk("ret1_value", bus.ret1_value_out, exp_val[idx]);
        chk("ret1_npc", bus.ret1_NPC_out, exp_npc[idx]);
        chk("ret1_mp", bus.ret1_mispredicted_out, exp_mp[idx]);
        m_ret++;
        if (exp_mp[idx]) m_flush = 1'b1;
      end
    end
    if (bus.ret2_valid_out === 1'b1) begin
      if (sbq.size() == 0 || m_flush || m_ret == 0) chk("ret2_spurious", bus.ret2_valid_out, 0);
      else begin
        e = sbq.pop_front(); idx = int'(e.tag);
        chk("ret2_tag", bus.ret2_tag_out, e.tag);
        chk("ret2_dest", bus.ret2_dest_out, e.dest);
        chk("ret2_value", bus.ret2_value_out, exp_val[idx]);
        chk("ret2_npc", bus.ret2_NPC_out, exp_npc[idx]);
        chk("ret2_mp", bus.ret2_mispredicted_out, exp_mp[idx]);
        m_ret++;
        if (exp_mp[idx]) m_flush = 1'b1;
      end
    end
    chk("flush", bus.flush_out, m_flush);
    if (m_flush) sbq.delete();
    chk("free_count", bus.free_count_out, D - m_count);
    chk("rob_empty", bus.rob_empty, m_count == 0);
    chk("rob_full", bus.rob_full, m_count > D - 2);

    n   = int'(bus.inst1_valid_in) + int'(bus.inst2_valid_in);
    acc = (n > 0) && !m_flush && (n <= D - m_count);
    t1  = (acc && bus.inst1_valid_in) ? 8'(m_tail) : NT;
    t2  = (acc && bus.inst2_valid_in) ? 8'(bus.inst1_valid_in ? (m_tail + 1) % D : m_tail) : NT;
    chk("inst1_tag", bus.inst1_tag_out, t1);
    chk("inst2_tag", bus.inst2_tag_out, t2);
    chk("stall", bus.dispatch_stall_out, (n > 0) && !m_flush && !acc);
    if (t1 != NT) push_entry(t1, bus.inst1_dest_in);
    if (t2 != NT) push_entry(t2, bus.inst2_dest_in);
    m_disp = acc ? n : 0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
    if (m_flush) begin m_tail = 0; m_count = 0; end
    else begin m_tail = (m_tail + m_disp) % D; m_count = m_count + m_disp - m_ret; end
    idle();
  endtask

  // Inputs driven by the caller stay live through the reset edge.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    idle();
    sbq.delete();
    m_tail = 0; m_count = 0; m_disp = 0; m_ret = 0; m_flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin exp_val[i] = '0; exp_npc[i] = '0; exp_mp[i] = 1'b0; end
    idle();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state and first dual dispatch / dual completion
    sample();
    chk("rst_ret1_valid", bus.ret1_valid_out, 0);
    chk("rst_ret1_tag", bus.ret1_tag_out, NT);
    chk("rst_ret2_tag", bus.ret2_tag_out, NT);
    chk("rst_ret1_dest", bus.ret1_dest_out, 0);
    chk("rst_ret1_value", bus.ret1_value_out, 0);
    chk("rst_free", bus.free_count_out, D);
    tick();
    set_dispatch(1, 5'd3, 1, 5'd4);
    sample();
    chk("d_tag1", bus.inst1_tag_out, 8'h00);
    chk("d_tag2", bus.inst2_tag_out, 8'h01);
    tick();
    set_cdb(8'h00, 64'hA, 64'h0, 0, 8'h01, 64'hB, 64'h0, 0);
    sample();
    chk("d_count2", bus.free_count_out, D - 2);
    chk("d_no_early_ret", bus.ret1_valid_out, 0);
    tick();
    sample();
    chk("d_ret1_valid", bus.ret1_valid_out, 1);
    chk("d_ret2_valid", bus.ret2_valid_out, 1);
    chk("d_ret1_dest", bus.ret1_dest_out, 3);
    chk("d_ret2_dest", bus.ret2_dest_out, 4);
    chk("d_ret1_value", bus.ret1_value_out, 64'hA);
    chk("d_ret2_value", bus.ret2_value_out, 64'hB);
    tick();
    sample();
    chk("d_empty", bus.rob_empty, 1);
    tick();

    // Fill to DEPTH-1, refuse a pair, accept a single, refuse when full
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_dispatch(1, 5'(i), 1, 5'(i + 8));
      sample(); tick();
    end
    set_dispatch(1, 5'd7, 0, 5'd0);
    sample(); tick();
    set_dispatch(1, 5'd9, 1, 5'd10);
    sample();
    chk("f_stall", bus.dispatch_stall_out, 1);
    chk("f_tag1_null", bus.inst1_tag_out, NT);
    chk("f_tag2_null", bus.inst2_tag_out, NT);
    tick();
    set_dispatch(1, 5'd11, 0, 5'd0);
    sample();
    chk("f_free1", bus.free_count_out, 1);
    chk("f_last_tag", bus.inst1_tag_out, 8'(D - 1));
    tick();
    set_dispatch(0, 5'd0, 1, 5'd12);
    sample();
    chk("f_full", bus.rob_full, 1);
    chk("f_free0", bus.free_count_out, 0);
    chk("f_single_stall", bus.dispatch_stall_out, 1);
    tick();

    // Reset mid-operation overrides dispatch and CDB
    set_dispatch(1, 5'd1, 1, 5'd2);
    bus.cdb1_tag_in = 8'h00; bus.cdb1_value_in = 64'hDEAD;
    do_reset();
    bus.rd_tag_in[0] = 8'h00;
    sample();
    chk("r_empty", bus.rob_empty, 1);
    chk("r_free", bus.free_count_out, D);
    chk("r_rd_ready", bus.rd_ready_out[0], 0);
    chk("r_rd_value", bus.rd_value_out[0], 0);
    tick();

    // Head+1 completes first; both retire together once head completes.
    // Then a shared CDB tag: cdb1's payload must win.
    set_dispatch(1, 5'd5, 1, 5'd6);
    sample(); tick();
    set_cdb(NT, 64'h0, 64'h0, 0, 8'h01, 64'h66, 64'h40, 0);
    sample(); tick();
    sample();
    chk("o_hold1", bus.ret1_valid_out, 0);
    chk("o_hold2", bus.ret2_valid_out, 0);
    tick();
    set_cdb(8'h00, 64'h55, 64'h44, 0, NT, 64'h0, 64'h0, 0);
    sample();
    chk("o_hold3", bus.ret1_valid_out, 0);
    tick();
    set_dispatch(1, 5'd7, 0, 5'd0);
    sample();
    chk("o_ret1_tag", bus.ret1_tag_out, 8'h00);
    chk("o_ret2_tag", bus.ret2_tag_out, 8'h01);
    tick();
    set_cdb(8'h02, 64'h111, 64'h0, 0, 8'h02, 64'h222, 64'h0, 0);
    sample(); tick();
    sample();
    chk("p_cdb1_wins", bus.ret1_value_out, 64'h111);
    tick();

    // Mispredicted branch retires: flush, suppressed dispatch, pointers cleared
    do_reset();
    set_dispatch(1, 5'd1, 1, 5'd2);
    sample(); tick();
    set_cdb(8'h00, 64'h11, 64'h100, 1, 8'h01, 64'h22, 64'h8, 0);
    sample(); tick();
    set_dispatch(1, 5'd3, 0, 5'd0);
    sample();
    chk("m_ret1_valid", bus.ret1_valid_out, 1);
    chk("m_ret2_valid", bus.ret2_valid_out, 0);
    chk("m_npc", bus.ret1_NPC_out, 64'h100);
    chk("m_flush", bus.flush_out, 1);
    chk("m_tag_null", bus.inst1_tag_out, NT);
    chk("m_no_stall", bus.dispatch_stall_out, 0);
    tick();
    set_dispatch(1, 5'd3, 0, 5'd0);
    sample();
    chk("m_count0", bus.free_count_out, D);
    chk("m_tail0", bus.inst1_tag_out, 8'h00);
    tick();
    set_cdb(8'h00, 64'h33, 64'h0, 0, NT, 64'h0, 64'h0, 0);
    sample(); tick();
    sample(); tick();

    // Advance tail to DEPTH-1, then dual dispatch across the wrap
    for (int i = 0; i < 3; i++) begin
      set_dispatch(1, 5'(10 + i), 1, 5'(20 + i));
      sample(); tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_cdb(8'(1 + 2 * i), 64'(16 + i), 64'(32 + i), 0, 8'(2 + 2 * i), 64'(48 + i), 64'(64 + i), 0);
      sample(); tick();
    end
    sample(); tick();
    sample();
    chk("w_empty", bus.rob_empty, 1);
    tick();
    set_dispatch(1, 5'd20, 1, 5'd21);
    sample();
    chk("w_tag1", bus.inst1_tag_out, 8'(D - 1));
    chk("w_tag2", bus.inst2_tag_out, 8'h00);
    tick();
    set_cdb(8'h00, 64'hC0, 64'h0, 0, 8'(D - 1), 64'hC7, 64'h0, 0);
    sample(); tick();
    sample();
    chk("w_ret1_tag", bus.ret1_tag_out, 8'(D - 1));
    chk("w_ret2_tag", bus.ret2_tag_out, 8'h00);
    chk("w_ret1_value", bus.ret1_value_out, 64'hC7);
    chk("w_ret2_value", bus.ret2_value_out, 64'hC0);
    tick();

    // Operand lookup with and without CDB bypass (head = tail = 1 here)
    for (int i = 0; i < 3; i++) begin
      set_dispatch(1, 5'(i + 1), 1, 5'(i + 4));
      sample(); tick();
    end
    bus.rd_tag_in[0] = 8'h05;
    bus.rd_tag_in[1] = NT;
    bus.rd_tag_in[2] = 8'h01;
    set_cdb(NT, 64'h0, 64'h0, 0, 8'h05, 64'h55, 64'h0, 0);
    sample();
`ifdef ROB_CDB_BYPASS_EN
    chk("b_ready_now", bus.rd_ready_out[0], 1);
    chk("b_value_now", bus.rd_value_out[0], 64'h55);
`else
    chk("b_ready_now", bus.rd_ready_out[0], 0);
    chk("b_value_now", bus.rd_value_out[0], 0);
`endif
    chk("b_null_ready", bus.rd_ready_out[1], 0);
    chk("b_null_value", bus.rd_value_out[1], 0);
    chk("b_inuse_ready", bus.rd_ready_out[2], 0);
    tick();
    bus.rd_tag_in[0] = 8'h05;
    sample();
    chk("b_ready_next", bus.rd_ready_out[0], 1);
    chk("b_value_next", bus.rd_value_out[0], 64'h55);
    tick();
    set_cdb(8'h01, 64'h71, 64'h0, 0, 8'h02, 64'h72, 64'h0, 0);
    sample(); tick();
    set_cdb(8'h03, 64'h73, 64'h0, 0, 8'h04, 64'h74, 64'h0, 0);
    sample(); tick();
    set_cdb(8'h06, 64'h76, 64'h0, 0, NT, 64'h0, 64'h0, 0);
    sample(); tick();
    repeat (3) begin sample(); tick(); end
    sample();
    chk("e_empty", bus.rob_empty, 1);
    chk("e_sb_drained", bus.free_count_out, D - int'(sbq.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rob_param.md
# rob_param

Parametrised two-wide reorder buffer. Sits between dispatch (map table / reservation stations), the two CDBs, and retirement (register file, branch predictor, fetch redirect, LSQ). Unlike the fixed 32-entry buffer, it has configurable depth and value width, an occupancy counter with all-or-nothing dispatch, and a precise flush when a mispredicted branch retires.

## Interface
- ROB_DEPTH, 32, entry count; power of two, 4..128; tag = entry index zero-extended to 8 bits, 8'hFF = null
- DATA_W, 64, width of result and NPC fields
- PTR_W, $clog2(ROB_DEPTH), head/tail pointer width
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- inst1_valid_in / inst2_valid_in  in  1  dispatch requests
- inst1_dest_in / inst2_dest_in  in  5  architectural destination
- inst1_tag_out / inst2_tag_out  out  8  allocated tag, 8'hFF if not dispatched
- dispatch_stall_out  out  1  request refused this cycle
- rd_tag_in[0..3]  in  8 each  operand lookup tags (inst1 a/b, inst2 a/b)
- rd_value_out[0..3]  out  DATA_W each  entry value
- rd_ready_out[0..3]  out  1 each  entry COMPLETE
- cdbN_tag_in (N=1,2)  in  8  completing tag, 8'hFF idle
- cdbN_value_in, cdbN_NPC_in  in  DATA_W  result, resolved next PC
- cdbN_mispredicted_in  in  1  branch mispredicted
- retN_valid_out (N=1,2)  out  1  retiring this cycle
- retN_dest_out  out  5; retN_value_out, retN_NPC_out  out  DATA_W; retN_tag_out  out  8; retN_mispredicted_out  out  1
- flush_out  out  1  mispredict retired; squash everything
- free_count_out  out  PTR_W+1  ROB_DEPTH - count
- rob_full  out  1  count > ROB_DEPTH-2
- rob_empty  out  1  count == 0

## Operation
- Entry state: EMPTY, INUSE, COMPLETE. Registers head, tail (next free slot), count (0..ROB_DEPTH). All pointer arithmetic is mod ROB_DEPTH.
- Dispatch: n = inst1_valid_in + inst2_valid_in. Accept only if n <= free_count_out and flush_out = 0; otherwise none accepted and dispatch_stall_out = 1 when n > 0. No credit for same-cycle retirement.
- Slot allocation: first valid instruction gets tail, second gets tail+1. If only inst2 is valid, it gets tail on inst2_tag_out. Entry becomes INUSE with dest latched and value/NPC/mispredict cleared.
- CDB: an entry in INUSE whose index equals cdbN_tag_in becomes COMPLETE and latches value, NPC, and mispredict. cdb1 wins if both CDBs carry the same tag. Tags matching EMPTY or COMPLETE entries, and tag 8'hFF, are ignored.
- Retire: ret1 = head COMPLETE. ret2 = ret1, head+1 COMPLETE, and head not mispredicted. Retired entries become EMPTY, head advances by the retire count, and outputs come from the entries.
- Flush: flush_out = any retiring entry mispredicted. At the next edge, all entries go EMPTY and head = tail = count = 0. Same-cycle dispatch is suppressed (tags 8'hFF, no stall). CDB writes that cycle are discarded.
- count_next = count + dispatched - retired (0 on flush).
- Operand read: index = rd_tag_in[PTR_W-1:0]; rd_ready_out = entry COMPLETE. For tag 8'hFF, ready = 0 and value = 0.

## Timing
- Reset values: head = tail = count = 0, all entries EMPTY with fields 0, dest 0. Outputs: tags 8'hFF, retN_valid_out 0, retN_dest/value/NPC 0, retN_tag_out 8'hFF, flush_out 0, dispatch_stall_out 0, rob_empty 1, rob_full 0, free_count_out ROB_DEPTH.
- All outputs are combinational from registered state plus current inputs. Dispatch tags are valid in the request cycle.
- A CDB broadcast in cycle N makes the entry COMPLETE at the N/N+1 edge. It can retire in cycle N+1 at the earliest. Dispatch-to-retire is at least 2 cycles.
- A freed slot is visible in free_count_out the cycle after retirement.
- Pointer wrap: tail = ROB_DEPTH-1 dual dispatch allocates ROB_DEPTH-1 and 0.
- Reset mid-operation overrides dispatch, CDB, and retire in that cycle.

## Configuration
- ROB_CDB_BYPASS_EN defined: if a read entry is INUSE and cdbN_tag_in matches, rd_ready_out = 1 and rd_value_out = cdb value, with cdb1 priority. Bypass is disabled during flush.
- ROB_CDB_BYPASS_EN undefined: ready/value reflect registered entry state only; bypass happens one cycle later.

## Test plan
- Reset, dispatch inst1 (dest 3) and inst2 (dest 4) -> tags 0x00/0x01, count 2. Broadcast both on cdb1/cdb2 with values 0xA/0xB -> next cycle ret1/ret2 valid, dest 3/4, values 0xA/0xB, rob_empty 1.
- Fill to ROB_DEPTH-1 entries, request two -> stall, tags 8'hFF, count unchanged. Request only inst1 -> tag ROB_DEPTH-1, rob_full 1, free_count_out 0.
- Complete head+1 before head -> no retire until head completes, then both retire the same cycle in order.
- Dispatch tags 0 and 1; tag 0 completes with mispredicted = 1 and NPC 0x100; tag 1 completes -> only ret1 valid, ret1_NPC_out 0x100, flush_out 1, next cycle count 0, head = tail = 0.
- Tail at ROB_DEPTH-1, dual dispatch -> tags ROB_DEPTH-1 and 0x00; retire across the wrap in order.
- With ROB_CDB_BYPASS_EN, read tag 5 while cdb2 broadcasts tag 5 with value 0x55 -> rd_ready_out 1, value 0x55 same cycle. Without the macro -> ready 0 that cycle, 1 the next.
